imem_boot_loader: RTL and testbench

Boot-time sequencer for the CPU instruction memory. Accepts a byte stream over a valid/ready handshake and packs each group of four bytes into a 32-bit instruction word. Writes each packed word to the fetch unit's instruction-memory write port at consecutive addresses from 0. Holds the core in reset while loading, then releases it after a programmable delay; this replaces backdoor preloading of instruction memory.

---
 rtl/imem_boot_loader.sv | 141 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot-time loader for the CPU instruction memory.
// Packs a valid/ready byte stream (LSB first) into 32-bit words, writes them
// to consecutive instruction-memory addresses from 0, and keeps the core in
// reset until RELEASE_DELAY cycles after the final write.
module imem_boot_loader #(
    parameter int DEPTH         = 256,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    // Hold counter runs 0 .. RELEASE_DELAY-1.
    localparam int CNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RELEASE_DELAY - 1);
    localparam logic [ADDR_W:0]   WORD_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       pack_q, pack_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ADDR_W:0]   words_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [31:0]       word_cur;

    // Next-state, packing and write-port decisions for the loader FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        pack_d     = pack_q;
        hold_cnt_d = hold_cnt_q;
        words_d    = words_loaded;
        we_d       = 1'b0;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        // Bytes already packed plus the incoming byte in its lane; upper lanes stay 0.
        word_cur   = {8'h00, pack_q} | ({24'h000000, byte_data} << {byte_idx_q, 3'b000});

        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = 2'd0;
                    pack_d     = 24'h000000;
                    words_d    = '0;
                    hold_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (byte_valid && byte_ready) begin
                    if (byte_idx_q == 2'd3 || byte_last) begin
                        we_d       = 1'b1;
                        addr_d     = words_loaded[ADDR_W-1:0];
                        wdata_d    = word_cur;
                        words_d    = words_loaded + (ADDR_W + 1)'(1);
                        byte_idx_d = 2'd0;
                        pack_d     = 24'h000000;
                        if (byte_last) begin
                            state_d    = S_HOLD;
                            hold_cnt_d = '0;
                        end else if (words_loaded == WORD_LAST) begin
                            // Memory full and the image has not ended.
                            state_d = S_ERROR;
                        end
                    end else begin
                        pack_d     = word_cur[23:0];
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; async reset returns everything to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= 2'd0;
            pack_q       <= 24'h000000;
            hold_cnt_q   <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'h0000_0000;
            byte_ready   <= 1'b0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            pack_q       <= pack_d;
            hold_cnt_q   <= hold_cnt_d;
            words_loaded <= words_d;
            imem_we      <= we_d;
            imem_addr    <= addr_d;
            imem_wdata   <= wdata_d;
            byte_ready   <= (state_d == S_LOAD);
            core_rst_n   <= (state_d == S_RUN);
            busy         <= (state_d == S_LOAD) || (state_d == S_HOLD);
            done         <= (state_d == S_RUN);
            error        <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes,
// an independent monitor pops and compares on every imem_we.
module tb_imem_boot_loader;

    localparam int DEPTH         = 4;
    localparam int ADDR_W        = 2;
    localparam int RELEASE_DELAY = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .RELEASE_DELAY(RELEASE_DELAY)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_last(byte_last),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .busy(busy),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        wr_t w;
        w.addr = ADDR_W'(addr);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Optional idle gap (with byte_last toggled high to show it is ignored), then hold
    // the byte until the loader accepts it. Returns in the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        logic acc;
        byte_valid = 1'b0;
        byte_last  = 1'b1;
        byte_data  = 8'hEE;
        repeat (gap) step();
        byte_valid = 1'b1;
        byte_data  = b;
        byte_last  = last;
        acc        = 1'b0;
        for (int n = 0; n < 50; n++) begin
            acc = byte_ready;
            step();
            if (acc) break;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            if (done) break;
            step();
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    // Scoreboard monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(e.addr));
                    check("write_data", imem_wdata, e.data);
                end
            end
            if (int'(busy) + int'(done) + int'(error) > 1)
                check("status_exclusive", {29'd0, busy, done, error}, 32'd0);
        end
    end

    logic [7:0] basic_img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    int         gap_tab   [8] = '{0, 2, 1, 0, 3, 0, 1, 2};

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int sent;
        logic acc;

        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'h00;
        #12;
        check_all_zero("reset");
        step();
        reset_n = 1'b1;
        step();

        // Basic load with exact release timing; a start during HOLD is ignored.
        pulse_start();
        check("start_byte_ready", 32'(byte_ready), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        expect_write(0, 32'h0010_0513);
        expect_write(1, 32'h0020_0593);
        for (int i = 0; i < 8; i++) send_byte(basic_img[i], (i == 7), 0);
        // Now in the write cycle W.
        check("w_busy", 32'(busy), 32'd1);
        check("w_byte_ready", 32'(byte_ready), 32'd0);
        check("w_words_loaded", 32'(words_loaded), 32'd2);
        check("w_core_rst_n", 32'(core_rst_n), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("w3_core_rst_n", 32'(core_rst_n), 32'd0);
        check("w3_busy", 32'(busy), 32'd1);
        step();
        check("w4_core_rst_n", 32'(core_rst_n), 32'd1);
        check("w4_done", 32'(done), 32'd1);
        check("w4_words_loaded", 32'(words_loaded), 32'd2);

        // Reload from RUN with a partial final word; start during LOAD is ignored.
        pulse_start();
        check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
        check("reload_words_loaded", 32'(words_loaded), 32'd0);
        check("reload_done", 32'(done), 32'd0);
        expect_write(0, 32'h0403_0201);
        expect_write(1, 32'h0000_0005);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b0, 0);
        pulse_start();
        send_byte(8'h05, 1'b1, 0);
        wait_done();
        check("partial_words_loaded", 32'(words_loaded), 32'd2);

        // Same image with idle gaps; byte_last is high while byte_valid is low.
        pulse_start();
        expect_write(0, 32'h0010_0513);
        expect_write(1, 32'h0020_0593);
        for (int i = 0; i < 8; i++) send_byte(basic_img[i], (i == 7), gap_tab[i]);
        wait_done();
        check("gaps_words_loaded", 32'(words_loaded), 32'd2);

        // Overflow: 20 bytes offered without last, only DEPTH words may be written.
        pulse_start();
        expect_write(0, 32'h2322_2120);
        expect_write(1, 32'h2726_2524);
        expect_write(2, 32'h2B2A_2928);
        expect_write(3, 32'h2F2E_2D2C);
        sent       = 0;
        byte_valid = 1'b1;
        byte_last  = 1'b0;
        for (int c = 0; c < 40 && sent < 20; c++) begin
            byte_data = 8'(8'h20 + sent);
            acc       = byte_ready;
            step();
            if (acc) sent++;
        end
        byte_valid = 1'b0;
        check("ovf_bytes_accepted", 32'(sent), 32'd16);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_byte_ready", 32'(byte_ready), 32'd0);
        check("ovf_core_rst_n", 32'(core_rst_n), 32'd0);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_words_loaded", 32'(words_loaded), 32'd4);
        pulse_start();
        check("ovf_restart_error", 32'(error), 32'd0);
        check("ovf_restart_byte_ready", 32'(byte_ready), 32'd1);
        check("ovf_restart_words", 32'(words_loaded), 32'd0);
        expect_write(0, 32'h0010_0513);
        expect_write(1, 32'h0020_0593);
        for (int i = 0; i < 8; i++) send_byte(basic_img[i], (i == 7), 0);
        wait_done();

        // Asynchronous reset two bytes into a word, then a fresh load.
        pulse_start();
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        step();
        reset_n = 1'b1;
        step();
        pulse_start();
        expect_write(0, 32'h4433_2211);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b1, 0);
        wait_done();
        check("midreset_words_loaded", 32'(words_loaded), 32'd1);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
